bitstream_buffer: RTL

//   Parametrised width-converting bit buffer with valid/ready handshakes on both sides.

---
 rtl/bitstream_buffer.sv | 90 +++++++++
 1 files changed

// File: rtl/bitstream_buffer.sv
// Width-converting bit buffer: IN_W-bit symbols in, OUT_W-bit words out, both LSB first.
// Valid/ready on both sides, with a flush that drains the final partial word zero-padded.
module bitstream_buffer #(
   parameter  int IN_W  = 4,
   parameter  int OUT_W = 1,
   parameter  int DEPTH = 32,
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             flush,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   if (DEPTH < IN_W + OUT_W) begin : g_bad_depth
      $error("bitstream_buffer: DEPTH must be >= IN_W + OUT_W");
   end

   localparam logic [LVL_W-1:0] IN_L    = LVL_W'(IN_W);
   localparam logic [LVL_W-1:0] OUT_L   = LVL_W'(OUT_W);
   localparam logic [LVL_W-1:0] FULL_TH = LVL_W'(DEPTH - IN_W);
   localparam logic [LVL_W-1:0] LVL_0   = {LVL_W{1'b0}};

   logic [DEPTH-1:0] data_q, data_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             flush_pending_q, flush_pending_d;

   logic             push_s, pop_s, flush_set_s;
   logic [LVL_W-1:0] pop_cnt_s, wr_pos_s;
   logic [DEPTH-1:0] shifted_s, in_ext_s;

   // Status, handshake and output decode; all driven from registers only.
   always_comb begin
      full      = (level_q > FULL_TH);
      empty     = (level_q == LVL_0);
      level     = level_q;
      in_ready  = !full && !flush_pending_q;
      out_valid = (level_q >= OUT_L) || (flush_pending_q && (level_q != LVL_0));
      out_data  = {OUT_W{1'b0}};
      for (int i = 0; i < OUT_W; i++) begin
         out_data[i] = data_q[i] & (LVL_W'(i) < level_q);
      end
   end

   // Next-state: optional shift-out first, then the new symbol lands just above the survivors.
   always_comb begin
      push_s = in_valid && in_ready;
      pop_s  = out_valid && out_ready;
      if (pop_s) begin
         pop_cnt_s = (level_q < OUT_L) ? level_q : OUT_L;
         shifted_s = data_q >> OUT_W;
      end else begin
         pop_cnt_s = LVL_0;
         shifted_s = data_q;
      end
      wr_pos_s = level_q - pop_cnt_s;
      in_ext_s = {{(DEPTH - IN_W){1'b0}}, in_data};
      if (push_s) begin
         data_d  = shifted_s | (in_ext_s << wr_pos_s);
         level_d = level_q + IN_L - pop_cnt_s;
      end else begin
         data_d  = shifted_s;
         level_d = level_q - pop_cnt_s;
      end
      flush_set_s     = flush && !flush_pending_q && ((level_q != LVL_0) || push_s);
      flush_pending_d = (flush_pending_q || flush_set_s) && (level_d != LVL_0);
   end

   // State registers with asynchronous clear.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         data_q          <= {DEPTH{1'b0}};
         level_q         <= LVL_0;
         flush_pending_q <= 1'b0;
      end else begin
         data_q          <= data_d;
         level_q         <= level_d;
         flush_pending_q <= flush_pending_d;
      end
   end

endmodule
